demux1to4_stream: RTL and testbench

- Registered 1-to-4 demultiplexer: the distribution counterpart of the 4:1 select mux.
- A single input stream is steered by select bits {s0, s1} to one of four output channels.
- Each output channel holds one word in a single-entry register with a valid/ready handshake.
- Sits between one producer and four independent consumers. A stalled consumer blocks only traffic addressed to it.

---
 rtl/demux1to4_stream.sv | 95 +++++++++
 tb/tb_demux1to4_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: {s0,s1} steers each input word into one of four
// single-entry output buffers, each with its own valid/ready handshake.
module demux1to4_stream #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s0,
  input  logic         s1,
  output logic [W-1:0] out0_data,
  output logic [W-1:0] out1_data,
  output logic [W-1:0] out2_data,
  output logic [W-1:0] out3_data,
  output logic         out0_valid,
  output logic         out1_valid,
  output logic         out2_valid,
  output logic         out3_valid,
  input  logic         out0_ready,
  input  logic         out1_ready,
  input  logic         out2_ready,
  input  logic         out3_ready,
  output logic         busy
);

  logic [1:0]   sel;
  logic [3:0]   full_q, full_d;
  logic [3:0]   out_ready;
  logic [3:0]   load;
  logic [3:0]   drain;
  logic [W-1:0] data_q [4];

  assign sel       = {s0, s1};
  assign out_ready = {out3_ready, out2_ready, out1_ready, out0_ready};

  // A full channel still accepts when its consumer drains in the same cycle.
  always_comb begin
    in_ready = ~flush & (~full_q[sel] | out_ready[sel]);
  end

  always_comb begin
    load   = '0;
    drain  = '0;
    full_d = full_q;
    for (int k = 0; k < 4; k++) begin
      load[k]  = in_valid & in_ready & (sel == 2'(k));
      drain[k] = full_q[k] & out_ready[k];
      if (load[k]) begin
        full_d[k] = 1'b1;
      end else if (drain[k]) begin
        full_d[k] = 1'b0;
      end
    end
    if (flush) begin
      full_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
    end else begin
      full_q <= full_d;
    end
  end

  // Data registers are deliberately left alone by flush and by drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  assign out0_data  = data_q[0];
  assign out1_data  = data_q[1];
  assign out2_data  = data_q[2];
  assign out3_data  = data_q[3];
  assign out0_valid = full_q[0];
  assign out1_valid = full_q[1];
  assign out2_valid = full_q[2];
  assign out3_valid = full_q[3];
  assign busy       = |full_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed bench for demux1to4_stream: stimulus pushes expected words into per-channel queues,
// a negedge monitor pops and compares on every output handshake.
module tb_demux1to4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s0, s1;
  logic [7:0] od [4];
  logic [3:0] ov;
  logic [3:0] rdy;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  demux1to4_stream #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .s0         (s0),
    .s1         (s1),
    .out0_data  (od[0]),
    .out1_data  (od[1]),
    .out2_data  (od[2]),
    .out3_data  (od[3]),
    .out0_valid (ov[0]),
    .out1_valid (ov[1]),
    .out2_valid (ov[2]),
    .out3_valid (ov[3]),
    .out0_ready (rdy[0]),
    .out1_ready (rdy[1]),
    .out2_ready (rdy[2]),
    .out3_ready (rdy[3]),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    case (k)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic clear_queues();
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  task automatic pop_check(input int k);
    logic [7:0] e;
    int         sz;
    case (k)
      0: sz = q0.size();
      1: sz = q1.size();
      2: sz = q2.size();
      default: sz = q3.size();
    endcase
    n_checks++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL spurious_out%0d: got data %0h with no word expected", k, od[k]);
    end else begin
      n_checks--;
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      chk($sformatf("sb_out%0d_data", k), 32'(od[k]), 32'(e));
    end
  endtask

  // Monitor: a handshake visible at negedge completes at the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && rdy[k]) pop_check(k);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one word; check in_ready against expectation and record it if accepted.
  task automatic drive(input int k, input logic [7:0] d, input logic exp_rdy, input string nm);
    in_data  = d;
    in_valid = 1'b1;
    {s0, s1} = 2'(k);
    #1;
    chk(nm, 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy) push(k, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_data = '0; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0; rdy = '0;
    #1;
    chk("reset_valid", 32'(ov), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_data0", 32'(od[0]), 32'h0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'h1);

    // Single route to ch2
    step(); drive(2, 8'hA5, 1'b1, "t1_ready");
    step(); in_valid = 1'b0;
    #1;
    chk("t1_valid", 32'(ov), 32'h4);
    chk("t1_data2", 32'(od[2]), 32'hA5);
    chk("t1_busy", 32'(busy), 32'h1);

    // Backpressure on ch2
    for (int i = 0; i < 5; i++) begin
      step(); drive(2, 8'h3C, 1'b0, "t2_stall_ready");
      chk("t2_hold_data2", 32'(od[2]), 32'hA5);
      chk("t2_hold_valid2", 32'(ov[2]), 32'h1);
    end
    step(); rdy[2] = 1'b1; drive(2, 8'h3C, 1'b1, "t2_release_ready");
    step(); rdy[2] = 1'b0; in_valid = 1'b0;
    #1;
    chk("t2_data2", 32'(od[2]), 32'h3C);
    chk("t2_valid2", 32'(ov[2]), 32'h1);

    // ch2 stalled must not block ch0
    step(); drive(0, 8'h11, 1'b1, "t3_ready");
    step(); in_valid = 1'b0;
    #1;
    chk("t3_data0", 32'(od[0]), 32'h11);
    chk("t3_valid0", 32'(ov[0]), 32'h1);
    chk("t3_data2", 32'(od[2]), 32'h3C);
    chk("t3_valid2", 32'(ov[2]), 32'h1);

    // Back-to-back streaming into ch1
    rdy[1] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(); drive(1, 8'(i), 1'b1, "t4_ready");
      if (i > 1) chk("t4_latency_data1", 32'(od[1]), 32'(i - 1));
    end
    step(); in_valid = 1'b0;
    #1;
    chk("t4_last_data1", 32'(od[1]), 32'h08);
    chk("t4_last_valid1", 32'(ov[1]), 32'h1);
    step(); rdy[1] = 1'b0;
    #1;
    chk("t4_drained_valid1", 32'(ov[1]), 32'h0);

    // Fill all four channels, then flush
    step(); drive(1, 8'h21, 1'b1, "t5_fill1");
    step(); drive(3, 8'h33, 1'b1, "t5_fill3");
    step(); in_valid = 1'b0;
    #1;
    chk("t5_all_full", 32'(ov), 32'hF);
    step(); flush = 1'b1; drive(3, 8'h77, 1'b0, "t5_flush_ready");
    step(); flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_flush_valid", 32'(ov), 32'h0);
    chk("t5_flush_busy", 32'(busy), 32'h0);
    chk("t5_flush_data3_kept", 32'(od[3]), 32'h33);
    clear_queues();

    // Async reset between edges with ch1 and ch3 full
    step(); drive(1, 8'h5A, 1'b1, "t6_fill1");
    step(); drive(3, 8'hC3, 1'b1, "t6_fill3");
    step(); in_valid = 1'b0;
    #1;
    chk("t6_pre_valid", 32'(ov), 32'hA);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(ov), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_data1", 32'(od[1]), 32'h0);
    chk("t6_async_data3", 32'(od[3]), 32'h0);
    clear_queues();
    step(); step();
    chk("t6_held_valid", 32'(ov), 32'h0);
    rst = 1'b0;
    #1;
    chk("t6_ready_after_release", 32'(in_ready), 32'h1);
    step();
    chk("t6_idle_valid", 32'(ov), 32'h0);
    rdy[3] = 1'b1;
    drive(3, 8'h99, 1'b1, "t6_resume_ready");
    step(); in_valid = 1'b0;
    #1;
    chk("t6_resume_data3", 32'(od[3]), 32'h99);
    chk("t6_resume_valid3", 32'(ov[3]), 32'h1);
    step(); rdy[3] = 1'b0;
    #1;
    chk("t6_resume_drained", 32'(ov[3]), 32'h0);
    chk("sb_empty", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
